// File: rtl/ensemble_pkg.sv
// Shared definitions for the ensemble vote collector: label width default,
// vote codes and the buffered per-classifier entry layout.
package ensemble_pkg;

   localparam int LABEL_WIDTH_DEFAULT = 8;

   localparam logic [1:0] VOTE_NONE = 2'd1;
   localparam logic [1:0] VOTE_MAJ  = 2'd2;
   localparam logic [1:0] VOTE_ALL  = 2'd3;

   typedef struct packed {
      logic [LABEL_WIDTH_DEFAULT-1:0] label;
      logic                           last;
   } fifo_entry_t;

endpackage

// File: rtl/ensemble_stream_fifo.sv
// Show-ahead synchronous FIFO: dout always presents the oldest entry while
// not empty. Pointers carry one extra wrap bit to tell full from empty.
module ensemble_stream_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_wr, do_rd;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset so it maps onto distributed RAM.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

   assign dout = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ensemble_vote_collector.sv
// Buffers three classifier result streams, joins one beat from each, takes a
// majority vote on the labels and emits one voted beat with a confidence code.
module ensemble_vote_collector
   import ensemble_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int KEEP_WIDTH  = 4,
   parameter int LABEL_WIDTH = LABEL_WIDTH_DEFAULT,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
   input  logic                  s_axis_tvalid_0,
   output logic                  s_axis_tready_0,
   input  logic                  s_axis_tlast_0,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
   input  logic                  s_axis_tvalid_1,
   output logic                  s_axis_tready_1,
   input  logic                  s_axis_tlast_1,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
   input  logic                  s_axis_tvalid_2,
   output logic                  s_axis_tready_2,
   input  logic                  s_axis_tlast_2,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  last_mismatch,
   output logic [31:0]           no_majority_count
);

   localparam int ENTRY_W = LABEL_WIDTH + 1;

   logic [2:0]             in_valid, in_last, fifo_full, fifo_empty, lst;
   logic [LABEL_WIDTH-1:0] in_label [3];
   logic [LABEL_WIDTH-1:0] lbl [3];
   logic [ENTRY_W-1:0]     fifo_dout [3];
   logic                   join_fire;
   logic [LABEL_WIDTH-1:0] vote_label;
   logic [1:0]             vote_code;

   logic                  tvalid_q, tvalid_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
   logic                  tlast_q, tlast_d;
   logic                  mismatch_q, mismatch_d;
   logic [31:0]           nm_count_q, nm_count_d;

   // tkeep and label-external tdata bits carry nothing the vote needs.
   logic unused_inputs;
   assign unused_inputs = ^{s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2,
                            s_axis_tdata_0[DATA_WIDTH-1:LABEL_WIDTH],
                            s_axis_tdata_1[DATA_WIDTH-1:LABEL_WIDTH],
                            s_axis_tdata_2[DATA_WIDTH-1:LABEL_WIDTH]};

   assign in_valid    = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
   assign in_last     = {s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};
   assign in_label[0] = s_axis_tdata_0[LABEL_WIDTH-1:0];
   assign in_label[1] = s_axis_tdata_1[LABEL_WIDTH-1:0];
   assign in_label[2] = s_axis_tdata_2[LABEL_WIDTH-1:0];

   assign s_axis_tready_0 = !fifo_full[0];
   assign s_axis_tready_1 = !fifo_full[1];
   assign s_axis_tready_2 = !fifo_full[2];

   assign join_fire = !(|fifo_empty) && (!tvalid_q || m_axis_tready);

   for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
      ensemble_stream_fifo #(
         .WIDTH (ENTRY_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .wr_en (in_valid[gi] && !fifo_full[gi]),
         .din   ({in_label[gi], in_last[gi]}),
         .full  (fifo_full[gi]),
         .rd_en (join_fire),
         .dout  (fifo_dout[gi]),
         .empty (fifo_empty[gi])
      );
      assign lbl[gi] = fifo_dout[gi][ENTRY_W-1:1];
      assign lst[gi] = fifo_dout[gi][0];
   end

   // With no majority, classifier 0 wins the tie-break.
   always_comb begin
      vote_label = lbl[0];
      vote_code  = VOTE_NONE;
      if (lbl[0] == lbl[1] && lbl[1] == lbl[2]) begin
         vote_code = VOTE_ALL;
      end else if (lbl[0] == lbl[1] || lbl[0] == lbl[2]) begin
         vote_code = VOTE_MAJ;
      end else if (lbl[1] == lbl[2]) begin
         vote_label = lbl[1];
         vote_code  = VOTE_MAJ;
      end
   end

   always_comb begin
      tvalid_d   = tvalid_q;
      tdata_d    = tdata_q;
      tkeep_d    = tkeep_q;
      tlast_d    = tlast_q;
      mismatch_d = mismatch_q;
      nm_count_d = nm_count_q;
      if (join_fire) begin
         tvalid_d = 1'b1;
         tdata_d  = '0;
         tdata_d[LABEL_WIDTH-1:0]           = vote_label;
         tdata_d[LABEL_WIDTH+1:LABEL_WIDTH] = vote_code;
         tkeep_d  = '1;
         tlast_d  = |lst;
         if ((|lst) && !(&lst)) mismatch_d = 1'b1;
         if (vote_code == VOTE_NONE) nm_count_d = nm_count_q + 32'd1;
      end else if (m_axis_tready) begin
         tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tvalid_q   <= 1'b0;
         tdata_q    <= '0;
         tkeep_q    <= '0;
         tlast_q    <= 1'b0;
         mismatch_q <= 1'b0;
         nm_count_q <= '0;
      end else begin
         tvalid_q   <= tvalid_d;
         tdata_q    <= tdata_d;
         tkeep_q    <= tkeep_d;
         tlast_q    <= tlast_d;
         mismatch_q <= mismatch_d;
         nm_count_q <= nm_count_d;
      end
   end

   assign m_axis_tvalid     = tvalid_q;
   assign m_axis_tdata      = tdata_q;
   assign m_axis_tkeep      = tkeep_q;
   assign m_axis_tlast      = tlast_q;
   assign last_mismatch     = mismatch_q;
   assign no_majority_count = nm_count_q;

endmodule
